// File: rtl/vadd_pkg.sv
// vadd_pkg: shared lane/width definitions for the fp32 vector adder and its companions.
package vadd_pkg;
    localparam int VEC_LANES = 16;
    localparam int FP_W      = 32;
    localparam int VEC_W     = VEC_LANES * FP_W;
    typedef logic [VEC_W-1:0] vec_t;
endpackage

// File: rtl/vadd_fifo_mem.sv
// vadd_fifo_mem: result storage with one write port and a registered, write-first read port.
module vadd_fifo_mem
    import vadd_pkg::*;
#(
    parameter int DATA_W = VEC_W,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    // A write into an empty FIFO lands on the head address, so forward it into the output register.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rdata <= '0;
        else        rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
endmodule

// File: rtl/vector_add_collect.sv
// vector_add_collect: credit-gated in-flight counter and FWFT result FIFO behind the vector adder.
// Optional sticky error flags are built when VADD_COLLECT_ERR_EN is defined.
module vector_add_collect
    import vadd_pkg::*;
#(
    parameter int DATA_W = VEC_W,
    parameter int DEPTH  = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  inflight,
    output logic              err_overflow,
    output logic              err_unexpected
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr, rd_ptr, rd_next;
    logic [CNT_W-1:0] occ_next, inf_next;
    logic             full, pop, push, fire, dec;

    assign issue_ready = ({1'b0, inflight} + {1'b0, occupancy}) < (CNT_W+1)'(DEPTH);
    assign full        = occupancy == CNT_W'(DEPTH);
    assign pop         = m_valid & m_ready;
    assign push        = res_valid & (!full | pop);
    assign fire        = issue_valid & issue_ready;
    assign dec         = res_valid & (inflight != '0);
    assign occ_next    = occupancy + CNT_W'(push) - CNT_W'(pop);
    assign inf_next    = inflight + CNT_W'(fire) - CNT_W'(dec);
    assign rd_next     = rd_ptr + AW'(pop);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            inflight  <= '0;
            m_valid   <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr + AW'(push);
            rd_ptr    <= rd_next;
            occupancy <= occ_next;
            inflight  <= inf_next;
            m_valid   <= occ_next != '0;
        end

    vadd_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (res_data),
        .raddr (rd_next),
        .rdata (m_data)
    );

`ifdef VADD_COLLECT_ERR_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            err_overflow   <= 1'b0;
            err_unexpected <= 1'b0;
        end else begin
            err_overflow   <= err_overflow | (res_valid & full & !pop);
            err_unexpected <= err_unexpected | (res_valid & (inflight == '0));
        end
`else
    assign err_overflow   = 1'b0;
    assign err_unexpected = 1'b0;
`endif
endmodule
